// File: rtl/tiny_rv_pkg.sv
// Shared types and constants for the tiny_rv Wishbone arbiter slice.
package tiny_rv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      ABORT  = 2'd3
   } arb_state_t;

   localparam logic ARB_M_DATA  = 1'b0;
   localparam logic ARB_M_FETCH = 1'b1;

   localparam int unsigned ARB_OUT_W = 4;
   localparam int unsigned ARB_WD_W  = 16;

endpackage

// File: rtl/tiny_rv_wb_arbiter_if.sv
// Pipelined Wishbone bundle; master drives request, slave drives response.
interface tiny_rv_wb_arbiter_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [29:0] addr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic        ack;
   logic        stall;
   logic        err;
   logic [31:0] rdat;

   modport master (
      output cyc, stb, we, addr, wdat, sel,
      input  ack, stall, err, rdat
   );

   modport slave (
      input  cyc, stb, we, addr, wdat, sel,
      output ack, stall, err, rdat
   );

endinterface

// File: rtl/tiny_rv_wb_watchdog.sv
// Counts armed cycles without a response; flags expiry on the last one.
module tiny_rv_wb_watchdog
   import tiny_rv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic arm_i,
   input  logic kick_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam logic [ARB_WD_W-1:0] LAST = ARB_WD_W'(TIMEOUT_CYCLES - 1);

   logic [ARB_WD_W-1:0] cnt_q, cnt_d;

   assign expired_o = arm_i & ~kick_i & ~clr_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i | kick_i | expired_o) begin
         cnt_d = '0;
      end else if (arm_i) begin
         cnt_d = cnt_q + ARB_WD_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tiny_rv_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter with outstanding limit and watchdog.
// TINY_RV_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module tiny_rv_wb_arbiter
   import tiny_rv_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic        i_clk,
   input  logic        i_reset_n,

   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   input  logic        i_m0_we,
   input  logic [29:0] i_m0_addr,
   input  logic [31:0] i_m0_data,
   input  logic [3:0]  i_m0_sel,
   output logic        o_m0_ack,
   output logic        o_m0_stall,
   output logic        o_m0_err,
   output logic [31:0] o_m0_data,

   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   input  logic        i_m1_we,
   input  logic [29:0] i_m1_addr,
   input  logic [31:0] i_m1_data,
   input  logic [3:0]  i_m1_sel,
   output logic        o_m1_ack,
   output logic        o_m1_stall,
   output logic        o_m1_err,
   output logic [31:0] o_m1_data,

   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [29:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data,

   output logic [1:0]  o_grant
);

   arb_state_t           state_q, state_d;
   logic [ARB_OUT_W-1:0] outst_q, outst_d;

   logic own0, own1, owned;
   logic own_cyc, own_stb;
   logic resp, full, accept;
   logic wd_arm, expired;
   logic pick1;

   assign own0  = (state_q == GRANT0);
   assign own1  = (state_q == GRANT1);
   assign owned = own0 | own1;

   assign o_grant = {own1, own0};

   assign own_cyc = (own0 & i_m0_cyc) | (own1 & i_m1_cyc);
   assign own_stb = (own0 & i_m0_stb) | (own1 & i_m1_stb);

   // A response in the same cycle frees a slot for the next strobe.
   assign resp = i_wb_ack | i_wb_err;
   assign full = (outst_q == ARB_OUT_W'(MAX_OUTSTANDING)) & ~resp;

   assign o_wb_cyc = own_cyc;
   assign o_wb_stb = own_cyc & own_stb & ~full;
   assign o_wb_we  = (own0 & i_m0_we) | (own1 & i_m1_we);

   assign o_wb_addr = own1 ? i_m1_addr :
                      own0 ? i_m0_addr : '0;
   assign o_wb_data = own1 ? i_m1_data :
                      own0 ? i_m0_data : '0;
   assign o_wb_sel  = own1 ? i_m1_sel  :
                      own0 ? i_m0_sel  : '0;

   assign accept = o_wb_stb & ~i_wb_stall;

   assign o_m0_stall = ~own0 | i_wb_stall | full;
   assign o_m1_stall = ~own1 | i_wb_stall | full;

   assign o_m0_ack = own0 & i_wb_ack;
   assign o_m1_ack = own1 & i_wb_ack;
   assign o_m0_err = own0 & (i_wb_err | expired);
   assign o_m1_err = own1 & (i_wb_err | expired);

   assign o_m0_data = own0 ? i_wb_data : '0;
   assign o_m1_data = own1 ? i_wb_data : '0;

   assign wd_arm = owned & (outst_q != '0);

   tiny_rv_wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (i_clk),
      .rst_ni   (i_reset_n),
      .arm_i    (wd_arm),
      .kick_i   (resp),
      .clr_i    (~owned),
      .expired_o(expired)
   );

`ifdef TINY_RV_ARB_RR_EN
   logic last_q, last_d;

   assign pick1 = (last_q == ARB_M_DATA);

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && state_d == GRANT0) begin
         last_d = ARB_M_DATA;
      end else if (state_q == IDLE && state_d == GRANT1) begin
         last_d = ARB_M_FETCH;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         last_q <= ARB_M_FETCH;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign pick1 = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (i_m0_cyc & i_m1_cyc) begin
               state_d = pick1 ? GRANT1 : GRANT0;
            end else if (i_m0_cyc) begin
               state_d = GRANT0;
            end else if (i_m1_cyc) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            if (expired)        state_d = ABORT;
            else if (!i_m0_cyc) state_d = IDLE;
         end
         GRANT1: begin
            if (expired)        state_d = ABORT;
            else if (!i_m1_cyc) state_d = IDLE;
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      outst_d = outst_q;
      if (accept & ~resp) begin
         outst_d = outst_q + ARB_OUT_W'(1);
      end else if (resp & ~accept & (outst_q != '0)) begin
         outst_d = outst_q - ARB_OUT_W'(1);
      end
      if (!owned || state_d != state_q) begin
         outst_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         outst_q <= outst_d;
      end
   end

endmodule

// File: tb/tb_tiny_rv_wb_arbiter.sv
// Random and directed bench for tiny_rv_wb_arbiter with a transaction-level model.
module tb_tiny_rv_wb_arbiter;

   localparam int MAXO = 4;
   localparam int TMO  = 8;
`ifdef TINY_RV_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] grant;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;

   tiny_rv_wb_arbiter_if m0 ();
   tiny_rv_wb_arbiter_if m1 ();
   tiny_rv_wb_arbiter_if s ();

   tiny_rv_wb_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_m0_cyc  (m0.cyc),
      .i_m0_stb  (m0.stb),
      .i_m0_we   (m0.we),
      .i_m0_addr (m0.addr),
      .i_m0_data (m0.wdat),
      .i_m0_sel  (m0.sel),
      .o_m0_ack  (m0.ack),
      .o_m0_stall(m0.stall),
      .o_m0_err  (m0.err),
      .o_m0_data (m0.rdat),
      .i_m1_cyc  (m1.cyc),
      .i_m1_stb  (m1.stb),
      .i_m1_we   (m1.we),
      .i_m1_addr (m1.addr),
      .i_m1_data (m1.wdat),
      .i_m1_sel  (m1.sel),
      .o_m1_ack  (m1.ack),
      .o_m1_stall(m1.stall),
      .o_m1_err  (m1.err),
      .o_m1_data (m1.rdat),
      .o_wb_cyc  (s.cyc),
      .o_wb_stb  (s.stb),
      .o_wb_we   (s.we),
      .o_wb_addr (s.addr),
      .o_wb_data (s.wdat),
      .o_wb_sel  (s.sel),
      .i_wb_ack  (s.ack),
      .i_wb_stall(s.stall),
      .i_wb_err  (s.err),
      .i_wb_data (s.rdat),
      .o_grant   (grant)
   );

   // Transaction-level model: who owns the bus, how many strobes are
   // pending, and how many silent cycles have passed with work pending.
   int mo = -1;
   bit mab = 1'b0;
   int mpend = 0;
   int mquiet = 0;
   int mlast = 1;

   logic        rsp, full, tmo, wcyc, wstb, acc;
   logic [1:0]  e_grant;
   logic        e_we;
   logic [29:0] e_addr;
   logic [31:0] e_wdat, e_d0, e_d1;
   logic [3:0]  e_sel;
   logic [140:0] ev, av;

   always @(negedge clk) begin
      cyc_n++;
      if (!rst_n) begin
         mo = -1; mab = 1'b0; mpend = 0; mquiet = 0; mlast = 1;
      end
      rsp  = s.ack | s.err;
      full = (mpend == MAXO) && !rsp;
      tmo  = (mo >= 0) && (mpend > 0) && !rsp && (mquiet == TMO - 1);
      wcyc = (mo == 0) ? m0.cyc : (mo == 1) ? m1.cyc : 1'b0;
      wstb = wcyc && ((mo == 0) ? m0.stb : m1.stb) && !full;
      e_grant = (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00;
      e_we   = (mo == 0) ? m0.we   : (mo == 1) ? m1.we   : 1'b0;
      e_addr = (mo == 0) ? m0.addr : (mo == 1) ? m1.addr : 30'd0;
      e_wdat = (mo == 0) ? m0.wdat : (mo == 1) ? m1.wdat : 32'd0;
      e_sel  = (mo == 0) ? m0.sel  : (mo == 1) ? m1.sel  : 4'd0;
      e_d0   = (mo == 0) ? s.rdat : 32'd0;
      e_d1   = (mo == 1) ? s.rdat : 32'd0;
      ev = {e_grant, wcyc, wstb, e_we, e_addr, e_wdat, e_sel,
            (mo == 0) && s.ack, (mo != 0) || s.stall || full,
            (mo == 0) && (s.err || tmo), e_d0,
            (mo == 1) && s.ack, (mo != 1) || s.stall || full,
            (mo == 1) && (s.err || tmo), e_d1};
      av = {grant, s.cyc, s.stb, s.we, s.addr, s.wdat, s.sel,
            m0.ack, m0.stall, m0.err, m0.rdat,
            m1.ack, m1.stall, m1.err, m1.rdat};
      checks++;
      if (av !== ev) begin
         errors++;
         $display("FAIL model cyc %0d: dut=%h model=%h", cyc_n, av, ev);
      end
      if (rst_n) begin
         if (mab) begin
            mab = 1'b0;
         end else if (mo < 0) begin
            if (m0.cyc && m1.cyc)  mo = (RR && mlast == 0) ? 1 : 0;
            else if (m0.cyc)       mo = 0;
            else if (m1.cyc)       mo = 1;
            if (mo >= 0) begin
               mlast = mo; mpend = 0; mquiet = 0;
            end
         end else if (tmo) begin
            mo = -1; mab = 1'b1; mpend = 0; mquiet = 0;
         end else if (!wcyc) begin
            mo = -1; mpend = 0; mquiet = 0;
         end else begin
            acc = wstb && !s.stall;
            if (rsp)            mquiet = 0;
            else if (mpend > 0) mquiet++;
            if (acc && !rsp)                  mpend++;
            else if (!acc && rsp && mpend > 0) mpend--;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.addr = '0; m0.wdat = '0; m0.sel = '0;
      m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.addr = '0; m1.wdat = '0; m1.sel = '0;
      s.ack = 0; s.stall = 0; s.err = 0; s.rdat = '0;
   endtask

   int acc_n;
   logic [8:1] errv;
   logic [1:0] rr_exp [3];

   initial begin
      idle_all();
      step(); #1;
      chk("rst_grant", grant, 0);
      chk("rst_cyc", s.cyc, 0);
      chk("rst_stalls", {m0.stall, m1.stall}, 2'b11);
      chk("rst_ackerr", {m0.ack, m1.ack, m0.err, m1.err, s.stb}, 0);
      step(); rst_n = 1;
      step();

      // contention, release and handoff gap
      m0.cyc = 1; m1.cyc = 1; #1;
      chk("pri_idle", grant, 0);
      step(); #1;
      chk("pri_win", grant, 2'b01);
      chk("pri_m1_stall", m1.stall, 1);
      step(); #1;
      chk("pri_hold", {grant, m1.stall}, 3'b011);
      step(); m0.cyc = 0; #1;
      chk("pri_drop_cyc", {grant, s.cyc}, 3'b010);
      step(); #1;
      chk("pri_gap", {grant, m1.stall}, 3'b001);
      step(); #1;
      chk("pri_handoff", {grant, m1.stall}, 3'b100);
      m1.cyc = 0; step(); step();

      rr_exp[0] = 2'b01;
      rr_exp[1] = RR ? 2'b10 : 2'b01;
      rr_exp[2] = 2'b01;
      for (int r = 0; r < 3; r++) begin
         m0.cyc = 1; m1.cyc = 1;
         step(); #1;
         chk($sformatf("rr_round%0d", r), grant, rr_exp[r]);
         m0.cyc = 0; m1.cyc = 0;
         step();
      end

      // outstanding limit on m1
      m1.cyc = 1; m1.stb = 1;
      step();
      acc_n = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (s.stb && !s.stall) acc_n++;
         step();
      end
      #1;
      chk("burst_accepted", acc_n, 4);
      chk("burst_stalled", m1.stall, 1);
      step(); s.ack = 1; #1;
      chk("burst_ack_unstall", {m1.stall, s.stb}, 2'b01);
      acc_n++;
      step(); s.ack = 0; #1;
      chk("burst_refull", m1.stall, 1);
      s.ack = 1; #1;
      if (s.stb && !s.stall) acc_n++;
      chk("burst_six", acc_n, 6);
      step(); s.ack = 0; m1.stb = 0; m1.cyc = 0;
      step(); step();

      // watchdog abort
      m0.cyc = 1; m0.stb = 1; m0.addr = 30'h100; m0.sel = 4'hf;
      step(); #1;
      chk("to_grant", grant, 2'b01);
      chk("to_addr", s.addr, 30'h100);
      chk("to_accept", {s.stb, m0.stall}, 2'b10);
      step(); m0.stb = 0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         errv[k] = m0.err;
         if (k < 8) step();
      end
      chk("to_err_pulse", errv, 8'b1000_0000);
      step(); m0.cyc = 0; m1.cyc = 1; #1;
      chk("to_abort", {s.cyc, m0.err, grant}, 0);
      step(); #1;
      chk("to_idle", grant, 0);
      step(); #1;
      chk("to_regrant", grant, 2'b10);
      m1.cyc = 0; step(); step();

      // read data routing
      m0.cyc = 1; m0.stb = 1; m0.addr = 30'h100;
      step();
      m0.stb = 0;
      step(); s.ack = 1; s.rdat = 32'hDEADBEEF; #1;
      chk("rd_data", m0.rdat, 32'hDEADBEEF);
      chk("rd_route", {m0.ack, m1.ack, m1.rdat}, {2'b10, 32'd0});
      step(); s.ack = 0; s.rdat = '0; m0.cyc = 0;
      step(); step();

      // reset with two strobes in flight
      m0.cyc = 1; m0.stb = 1;
      step(); step();
      m0.stb = 0;
      step(); #1;
      chk("mid_pre", {grant, s.cyc}, 3'b011);
      rst_n = 0; #1;
      chk("mid_rst", {grant, s.cyc, m0.stall}, 4'b0001);
      idle_all();
      step(); rst_n = 1;
      step();

      for (int n = 0; n < 3000; n++) begin
         if (m0.cyc) m0.cyc = ($urandom_range(0, 9) != 0);
         else        m0.cyc = ($urandom_range(0, 3) == 0);
         if (m1.cyc) m1.cyc = ($urandom_range(0, 9) != 0);
         else        m1.cyc = ($urandom_range(0, 3) == 0);
         m0.stb = m0.cyc & 1'($urandom_range(0, 1));
         m1.stb = m1.cyc & 1'($urandom_range(0, 1));
         m0.we = 1'($urandom); m0.addr = 30'($urandom);
         m0.wdat = $urandom;   m0.sel = 4'($urandom);
         m1.we = 1'($urandom); m1.addr = 30'($urandom);
         m1.wdat = $urandom;   m1.sel = 4'($urandom);
         s.stall = ($urandom_range(0, 3) == 0);
         s.ack = ($urandom_range(0, 4) == 0);
         s.err = ($urandom_range(0, 39) == 0);
         s.rdat = $urandom;
         step();
      end
      idle_all();
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tiny_rv_wb_arbiter.md
# tiny_rv_wb_arbiter

Two-master pipelined Wishbone arbiter that shares the core's single external bus between the exec-stage memory unit (master 0, data) and the instruction fetch/icache refill path (master 1). It grants one master at a time and holds the grant for that master's whole `cyc` window. It counts outstanding requests and routes ack/err/data back to the owner. A watchdog aborts cycles whose slave never acknowledges.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum in-flight strobes per grant, range 1..15.
- `TIMEOUT_CYCLES`, default 255: cycles with outstanding > 0 and no ack/err before abort, range 1..65535.

Ports:
- `i_clk` in 1: the only clock.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we` in 1 each: data master control.
- `i_m0_addr` in 30: data master word address.
- `i_m0_data` in 32: data master write data.
- `i_m0_sel` in 4: data master byte select.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err` out 1 each: data master response.
- `o_m0_data` out 32: data master read data.
- `i_m1_*` / `o_m1_*`: identical set for the fetch master.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: slave side.
- `o_wb_addr` out 30, `o_wb_data` out 32, `o_wb_sel` out 4: slave side.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err` in 1 each; `i_wb_data` in 32: slave responses.
- `o_grant` out 2: one-hot current owner (bit0 = m0); 0 when idle.

## Operation
- FSM states:
  - `IDLE`: no owner; `o_wb_cyc`=0; all `o_mX_stall`=1.
  - `GRANT0` / `GRANT1`: owner's cyc/stb/we/addr/data/sel forwarded combinationally.
  - `ABORT`: one cycle with `o_wb_cyc`=0, then `IDLE`.
- `IDLE` -> `GRANTx` on the next edge when `i_mx_cyc`=1. With both requesting, the winner is chosen per Configuration.
- `GRANTx` -> `IDLE` when `i_mx_cyc`=0 (sampled). The outstanding counter clears.
- `GRANTx` -> `ABORT` when the watchdog expires.
- `o_wb_stb` = owner stb and not (outstanding == `MAX_OUTSTANDING`).
- `o_mx_stall` = not owner, or `i_wb_stall`, or outstanding full.
- Outstanding counter:
  - +1 on an accepted strobe (`o_wb_stb` and not `i_wb_stall`).
  - −1 on `i_wb_ack` or `i_wb_err`.
  - Simultaneous accept and response: net 0.
  - Responses at outstanding 0 are discarded, with no underflow.
- Routing:
  - `i_wb_ack`, `i_wb_err` and `i_wb_data` go only to the owner.
  - Non-owner ack/err are 0; non-owner data is 0.
- Watchdog:
  - Counts while outstanding > 0 and no ack/err.
  - Resets on any ack/err or on a new grant.
  - At `TIMEOUT_CYCLES` it asserts a 1-cycle `o_mx_err` to the owner, then `ABORT`.
  - The master must drop `cyc` on err.
- Reset, asynchronous:
  - State `IDLE`, counters 0, `o_grant`=0.
  - All `o_*` ack/err/cyc/stb = 0, stalls = 1.
  - Round-robin pointer = "last grant m1".
  - Reset mid-transfer drops `o_wb_cyc` immediately.

## Timing
- Arbitration latency: 1 cycle from `cyc` asserted in `IDLE` to the first forwardable `stb`.
- Release: owner drops `cyc` at edge N -> `IDLE` during N+1 -> a new grant is visible at N+2. There is no direct owner-to-owner handoff.
- Forward path (stb/addr/data) and return path (ack/err/data) are combinational, with zero added latency once granted.
- Err pulse width is exactly 1 cycle. `ABORT` lasts exactly 1 cycle.

## Configuration
- `TINY_RV_ARB_RR_EN` defined: round-robin. On simultaneous requests in `IDLE`, the master not granted last wins. A pointer register updates on each grant.
- Undefined: fixed priority; m0 (data) always wins simultaneous requests. No pointer register.

## Structure
- Shared package `tiny_rv_pkg`:
  - Arbiter state enum `arb_state_t` (`IDLE`, `GRANT0`, `GRANT1`, `ABORT`).
  - Master index constants `ARB_M_DATA`=0, `ARB_M_FETCH`=1.
- Sub-module `tiny_rv_wb_watchdog`: parameterised timeout counter with inputs `arm`, `kick`, `clr` and output `expired`. Instantiated once.

## Test plan
- Reset asserted mid-transfer (m0, 2 outstanding) -> same cycle: `o_wb_cyc`=0, `o_grant`=0, `o_m0_stall`=1.
- m0 and m1 raise `cyc` the same cycle, fixed priority -> `o_grant`=01 next cycle; m1 stalled until m0 drops `cyc`; m1 granted 2 cycles after that.
- With `TINY_RV_ARB_RR_EN`: 3 back-to-back contended rounds -> grants m0, m1, m0.
- m1 issues 6 strobes, slave never stalls, no acks, `MAX_OUTSTANDING`=4 -> exactly 4 accepted; `o_m1_stall`=1 until the first ack; 5th accepted the cycle of that ack.
- m0 read to `addr` 0x100, slave silent, `TIMEOUT_CYCLES`=8 -> `o_m0_err` single pulse 8 cycles after acceptance; `o_wb_cyc`=0 next cycle; `IDLE` after that.
- m0 read returns `i_wb_data`=0xDEADBEEF with ack -> `o_m0_data`=0xDEADBEEF, `o_m0_ack`=1, `o_m1_ack`=0, `o_m1_data`=0.
